fsm_table_sequencer: RTL and testbench
======================================

// Module: fsm_table_sequencer
// PURPOSE
//  Programmable, table-driven Mealy FSM engine with its run controller.
//  Holds a 16x6 transition table indexed by {a, state[2:0]}: entry[5:3] = next state, entry[2:0] = output.
//  Config port loads the table; start/stop sequence the engine through IDLE/RUN/HALT.
//  Replaces hard-wired pattern FSMs: one engine, reprogrammed per pattern.
// PARAMETERS
//  INIT_STATE  3'd2  state loaded on start from IDLE
//  STEP_W      8     width of the saturating step counter
// PORTS
//  clk        in   1       single clock, rising edge
//  res        in   1       asynchronous, active-low reset
//  cfg_valid  in   1       table write request
//  cfg_ready  out  1       table write accepted when cfg_valid & cfg_ready at posedge clk
//  cfg_addr   in   4       table entry index {a, state}
//  cfg_data   in   6       {next_state[2:0], out[2:0]}
//  start      in   1       enter or resume RUN
//  stop       in   1       RUN->HALT; HALT->IDLE
//  a          in   1       FSM input, sampled each RUN cycle
//  saida      out  3       FSM output (combinational, Mealy)
//  state      out  3       current FSM state register
//  running    out  1       1 iff mode == RUN
//  steps      out  STEP_W  transitions taken since last start from IDLE
// BEHAVIOUR
//  Reset (res=0, async): mode=IDLE, state=0, steps=0, all 16 table entries=6'b0; resulting outputs: saida=0, running=0, cfg_ready=1.
//  Mode FSM (2-bit), evaluated at posedge clk:
//   IDLE: stop -> IDLE; start & ~stop -> RUN, state<=INIT_STATE, steps<=0.
//   RUN : stop -> HALT (state, steps frozen); else state<=table[{a,state}][5:3], steps<=steps+1.
//   HALT: stop -> IDLE (state, steps kept for inspection); start & ~stop -> RUN, resume from current state/steps.
//   start & stop in the same cycle: stop wins in every mode.
//  saida = table[{a,state}][2:0] in RUN and HALT; 3'd0 in IDLE. Zero-latency from a and state.
//  cfg_ready = (mode != RUN). Accepted write updates the entry at that posedge; new contents are visible to reads from the next cycle.
//  cfg_valid in RUN: ignored, no side effects; master holds the request until cfg_ready.
//  Write and start in the same cycle from IDLE/HALT: the write completes, then RUN begins next cycle using the updated table.
//  steps saturates at all-ones; no wrap.
//  First RUN transition occurs on the first posedge after the cycle in which mode became RUN.
//  Reset mid-RUN: immediate IDLE, table cleared; table must be reloaded.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds input port step (1b). In HALT, step & ~start & ~stop performs exactly one
//   transition (state/steps updated as in RUN) and stays in HALT. step is ignored in IDLE and RUN.
//  SINGLE_STEP_EN undefined: no step port; HALT only leaves via start/stop.
// STRUCTURE
//  Package fsm_seq_pkg: mode encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2), ENTRY_W=6, ADDR_W=4, ST_W=3.
//  Sub-module fsm_table_ram: 16x6 register file, 1 sync write port, 1 async read port, async active-low clear.
//  Top: mode FSM, state register, step counter, output mux.
// TESTING
//  1 Reset: res=0 with any inputs -> running=0, saida=0, steps=0, cfg_ready=1, state=0.
//  2 Load [2]=6'b100_010, [4]=6'b010_100, [12]=6'b011_100; start, a=0 -> state 2,4,2,4..., saida 2,4,2,4...;
//     a=1 while state=4 -> next state 3, saida=4.
//  3 Mid-RUN stop -> HALT: state/steps frozen; cfg_ready=1; write [3]=6'b010_111; start -> resumes from held state, steps keep counting.
//  4 start=stop=1 in IDLE -> stays IDLE; in RUN -> HALT; cfg_valid held in RUN -> no write until HALT, then write lands.
//  5 STEP_W=8, 300 RUN cycles on a 2-cycle loop -> steps=255 and holds.
//  6 Assert res mid-RUN -> same cycle mode=IDLE, saida=0; table reads 0 after release.
//  7 SINGLE_STEP_EN: HALT, three step pulses -> exactly 3 transitions, steps+3, running stays 0.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared encodings and sizes for the table-driven FSM sequencer.
package fsm_seq_pkg;

  localparam int ENTRY_W     = 6;
  localparam int ADDR_W      = 4;
  localparam int ST_W        = 3;
  localparam int NUM_ENTRIES = 16;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_HALT = 2'd2
  } mode_e;

endpackage

// File: rtl/fsm_table_ram.sv
// 16x6 transition table: one synchronous write port, one asynchronous read port,
// asynchronous active-low clear of every entry.
module fsm_table_ram
  import fsm_seq_pkg::*;
(
  input  logic               clk,
  input  logic               res,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_r [NUM_ENTRIES];

  // Table storage: cleared on reset, written on accepted config beats
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fsm_table_sequencer.sv
// Table-driven Mealy FSM engine with IDLE/RUN/HALT run controller.
// Optional feature macro: SINGLE_STEP_EN (adds the step port for HALT single-stepping).
module fsm_table_sequencer
  import fsm_seq_pkg::*;
#(
  parameter logic [ST_W-1:0] INIT_STATE = 3'd2,
  parameter int              STEP_W     = 8
)
(
  input  logic               clk,
  input  logic               res,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  input  logic               start,
  input  logic               stop,
  input  logic               a,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [ST_W-1:0]    saida,
  output logic [ST_W-1:0]    state,
  output logic               running,
  output logic [STEP_W-1:0]  steps
);

  mode_e               mode_r, mode_s;
  logic [ST_W-1:0]     state_r, state_s;
  logic [STEP_W-1:0]   steps_r, steps_s, steps_inc_s;
  logic [ENTRY_W-1:0]  entry_s;
  logic                cfg_we_s;

  assign cfg_we_s = cfg_valid & cfg_ready;

  fsm_table_ram u_table (
    .clk   (clk),
    .res   (res),
    .we    (cfg_we_s),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr ({a, state_r}),
    .rdata (entry_s)
  );

  // Saturating increment so a long run parks at all-ones instead of wrapping
  always_comb begin
    if (&steps_r) begin
      steps_inc_s = steps_r;
    end else begin
      steps_inc_s = steps_r + {{(STEP_W-1){1'b0}}, 1'b1};
    end
  end

  // Mode/state/step next-value logic; stop has priority over start everywhere
  always_comb begin
    mode_s  = mode_r;
    state_s = state_r;
    steps_s = steps_r;
    case (mode_r)
      MODE_IDLE: begin
        if (stop) begin
          mode_s = MODE_IDLE;
        end else if (start) begin
          mode_s  = MODE_RUN;
          state_s = INIT_STATE;
          steps_s = {STEP_W{1'b0}};
        end else begin
          mode_s = MODE_IDLE;
        end
      end
      MODE_RUN: begin
        if (stop) begin
          mode_s = MODE_HALT;
        end else begin
          state_s = entry_s[5:3];
          steps_s = steps_inc_s;
        end
      end
      MODE_HALT: begin
        if (stop) begin
          mode_s = MODE_IDLE;
        end else if (start) begin
          mode_s = MODE_RUN;
`ifdef SINGLE_STEP_EN
        end else if (step) begin
          state_s = entry_s[5:3];
          steps_s = steps_inc_s;
`endif
        end else begin
          mode_s = MODE_HALT;
        end
      end
      default: begin
        mode_s = MODE_IDLE;
      end
    endcase
  end

  // Engine registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mode_r  <= MODE_IDLE;
      state_r <= {ST_W{1'b0}};
      steps_r <= {STEP_W{1'b0}};
    end else begin
      mode_r  <= mode_s;
      state_r <= state_s;
      steps_r <= steps_s;
    end
  end

  // Mealy output is blanked while idle so a stale state never leaks out
  always_comb begin
    if (mode_r == MODE_IDLE) begin
      saida = {ST_W{1'b0}};
    end else begin
      saida = entry_s[2:0];
    end
  end

  assign cfg_ready = (mode_r != MODE_RUN);
  assign running   = (mode_r == MODE_RUN);
  assign state     = state_r;
  assign steps     = steps_r;

endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Directed self-checking bench for fsm_table_sequencer; expectations queue on a scoreboard.
// Define SINGLE_STEP_EN for both RTL and bench to exercise the step port.
module tb_fsm_table_sequencer;

  logic       clk;
  logic       res;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_addr;
  logic [5:0] cfg_data;
  logic       start;
  logic       stop;
  logic       a;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic [2:0] saida;
  logic [2:0] state;
  logic       running;
  logic [7:0] steps;

  localparam int SIG_STATE = 0;
  localparam int SIG_SAIDA = 1;
  localparam int SIG_STEPS = 2;
  localparam int SIG_RUN   = 3;
  localparam int SIG_RDY   = 4;

  typedef struct {
    int         sel;
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_bad;

  fsm_table_sequencer #(.INIT_STATE(3'd2), .STEP_W(8)) dut (
    .clk       (clk),
    .res       (res),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .stop      (stop),
    .a         (a),
`ifdef SINGLE_STEP_EN
    .step      (step),
`endif
    .saida     (saida),
    .state     (state),
    .running   (running),
    .steps     (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SIG_STATE: observe = {5'd0, state};
      SIG_SAIDA: observe = {5'd0, saida};
      SIG_STEPS: observe = steps;
      SIG_RUN:   observe = {7'd0, running};
      SIG_RDY:   observe = {7'd0, cfg_ready};
      default:   observe = 8'hxx;
    endcase
  endfunction

  task automatic expect_sig(input int sel, input string tag, input logic [7:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = observe(e.sel);
      n_vec++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [5:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    res = 1'b0;
    cfg_valid = 1'b1;
    cfg_addr = 4'd9;
    cfg_data = 6'h3f;
    start = 1'b1;
    stop = 1'b0;
    a = 1'b1;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    // 1: reset with arbitrary inputs applied
    #12;
    expect_sig(SIG_RUN,   "rst_running", 8'd0);
    expect_sig(SIG_SAIDA, "rst_saida",   8'd0);
    expect_sig(SIG_STEPS, "rst_steps",   8'd0);
    expect_sig(SIG_RDY,   "rst_ready",   8'd1);
    expect_sig(SIG_STATE, "rst_state",   8'd0);
    drain();
    cfg_valid = 1'b0;
    start = 1'b0;
    a = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);
    res = 1'b1;
    tick();

    // 2: load pattern, run 2,4,2,4 then branch on a=1
    cfg_write(4'd2,  6'b100_010);
    cfg_write(4'd4,  6'b010_100);
    cfg_write(4'd12, 6'b011_100);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_sig(SIG_RUN,   "run_enter",  8'd1);
    expect_sig(SIG_STATE, "run_init",   8'd2);
    expect_sig(SIG_SAIDA, "run_out0",   8'd2);
    expect_sig(SIG_STEPS, "run_steps0", 8'd0);
    expect_sig(SIG_RDY,   "run_ready",  8'd0);
    drain();
    tick();
    expect_sig(SIG_STATE, "run_st1", 8'd4);
    expect_sig(SIG_SAIDA, "run_out1", 8'd4);
    expect_sig(SIG_STEPS, "run_steps1", 8'd1);
    drain();
    tick();
    expect_sig(SIG_STATE, "run_st2", 8'd2);
    expect_sig(SIG_SAIDA, "run_out2", 8'd2);
    drain();
    tick();
    expect_sig(SIG_STATE, "run_st3", 8'd4);
    expect_sig(SIG_STEPS, "run_steps3", 8'd3);
    drain();

    // 3: stop into HALT, reprogram, resume
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_sig(SIG_RUN,   "halt_running", 8'd0);
    expect_sig(SIG_STATE, "halt_state",   8'd4);
    expect_sig(SIG_STEPS, "halt_steps",   8'd3);
    expect_sig(SIG_RDY,   "halt_ready",   8'd1);
    drain();
    tick();
    expect_sig(SIG_STATE, "halt_frozen", 8'd4);
    drain();
    cfg_write(4'd3, 6'b010_111);
    a = 1'b1;
    #1;
    expect_sig(SIG_SAIDA, "mealy_a1", 8'd4);
    drain();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_sig(SIG_STATE, "resume_state", 8'd4);
    expect_sig(SIG_STEPS, "resume_steps", 8'd3);
    drain();
    tick();
    expect_sig(SIG_STATE, "branch_state", 8'd3);
    expect_sig(SIG_STEPS, "resume_count", 8'd4);
    drain();
    a = 1'b0;
    #1;
    expect_sig(SIG_SAIDA, "new_entry_out", 8'd7);
    drain();
    tick();
    expect_sig(SIG_STATE, "new_entry_next", 8'd2);
    expect_sig(SIG_STEPS, "count5", 8'd5);
    drain();

    // 4: start+stop priority, write held off during RUN
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    expect_sig(SIG_RUN,   "ss_run_to_halt", 8'd0);
    expect_sig(SIG_STATE, "ss_state_kept",  8'd2);
    drain();
    tick();
    stop = 1'b0;
    expect_sig(SIG_SAIDA, "idle_saida",  8'd0);
    expect_sig(SIG_STEPS, "idle_steps",  8'd5);
    drain();
    start = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_sig(SIG_RUN, "ss_idle_stays", 8'd0);
    drain();
    tick();
    start = 1'b0;
    expect_sig(SIG_RUN,   "restart_run",   8'd1);
    expect_sig(SIG_STEPS, "restart_steps", 8'd0);
    drain();
    cfg_valid = 1'b1;
    cfg_addr = 4'd2;
    cfg_data = 6'b010_001;
    tick();
    tick();
    expect_sig(SIG_STATE, "held_wr_state", 8'd2);
    expect_sig(SIG_SAIDA, "held_wr_ignored", 8'd2);
    drain();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_sig(SIG_SAIDA, "held_wr_pending", 8'd2);
    drain();
    tick();
    cfg_valid = 1'b0;
    expect_sig(SIG_SAIDA, "held_wr_landed", 8'd1);
    drain();

    // 5: saturating step counter on a two-state loop
    cfg_write(4'd2, 6'b100_010);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_sig(SIG_STEPS, "sat_resume", 8'd2);
    drain();
    for (int i = 0; i < 252; i++) tick();
    expect_sig(SIG_STEPS, "sat_254", 8'd254);
    drain();
    tick();
    expect_sig(SIG_STEPS, "sat_255", 8'd255);
    drain();
    for (int i = 0; i < 47; i++) tick();
    expect_sig(SIG_STEPS, "sat_hold", 8'd255);
    expect_sig(SIG_RUN,   "sat_running", 8'd1);
    drain();

    // 6: asynchronous reset in the middle of RUN
    #3;
    res = 1'b0;
    #1;
    expect_sig(SIG_RUN,   "arst_running", 8'd0);
    expect_sig(SIG_SAIDA, "arst_saida",   8'd0);
    expect_sig(SIG_STATE, "arst_state",   8'd0);
    expect_sig(SIG_STEPS, "arst_steps",   8'd0);
    drain();
    @(negedge clk);
    res = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_sig(SIG_STATE, "post_rst_init",  8'd2);
    expect_sig(SIG_SAIDA, "post_rst_table", 8'd0);
    drain();
    tick();
    expect_sig(SIG_STATE, "post_rst_next", 8'd0);
    drain();

`ifdef SINGLE_STEP_EN
    // 7: single-step from HALT
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cfg_write(4'd0, 6'b001_000);
    cfg_write(4'd1, 6'b010_000);
    cfg_write(4'd2, 6'b011_000);
    expect_sig(SIG_STEPS, "ss_base", 8'd1);
    drain();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      expect_sig(SIG_RUN,   "step_running", 8'd0);
      expect_sig(SIG_STEPS, "step_count",   8'(2 + i));
      drain();
      tick();
    end
    expect_sig(SIG_STATE, "step_state", 8'd3);
    expect_sig(SIG_STEPS, "step_total", 8'd4);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
